wb_bypass_pipe: RTL and testbench
=================================

// Module: wb_bypass_pipe
// PURPOSE
//   Parametrised successor to the RegDst/ALUSrc/MemToReg select logic for the pipelined core.
//   Holds the EX/MEM (M) and MEM/WB (W) pipeline registers for the destination-register and
//   write-back path, and drives the register-file write port (wb_*).
//   Resolves the write-back data per WB_SEL and forwards M/W results to NUM_OPS read operands.
//   Flags load-use hazards to the decode stall logic.
// PARAMETERS
//   DATA_W   32  datapath width
//   RADDR_W  5   register address width; register 0 is hard zero
//   NUM_OPS  2   number of forwarded read operands
// PORTS
//   clk             in   1               clock, rising edge
//   rst_n           in   1               asynchronous, active-low reset
//   stall           in   1               freeze M and W registers
//   flush           in   1               kill M and W contents (sync)
//   ex_valid        in   1               EX stage holds a real instruction
//   ex_wr_en        in   1               instruction writes a register
//   ex_rt, ex_rd    in   RADDR_W each    candidate destinations
//   ex_reg_dst      in   1               1: dest=ex_rd, 0: dest=ex_rt
//   ex_wb_sel       in   2               00/10 ALU, 01 extended imm, 11 memory
//   ex_alu_res      in   DATA_W          ALU result
//   ex_ext_res      in   DATA_W          sign/zero-extended immediate
//   mem_rd_data     in   DATA_W          data-memory read data, valid during M stage
//   op_addr         in   NUM_OPS*RADDR_W read addresses (operand i at [i*RADDR_W +: RADDR_W])
//   op_rf_data      in   NUM_OPS*DATA_W  register-file read data per operand
//   op_data         out  NUM_OPS*DATA_W  forwarded operand data
//   load_use        out  1               OR of per-operand load-use hazards
//   wb_we           out  1               register-file write enable
//   wb_addr         out  RADDR_W         write address
//   wb_data         out  DATA_W          write data
// BEHAVIOUR
//   - Reset (rst_n=0, async): M/W valid=0, all M/W fields 0; wb_we=0, wb_addr=0, wb_data=0.
//   - M capture (posedge, !stall, !flush):
//       m_valid <= ex_valid & ex_wr_en
//       m_dst   <= ex_reg_dst ? ex_rd : ex_rt
//       m_sel, m_alu, m_ext <= ex_*
//   - W capture (posedge, !stall, !flush):
//       w_valid <= m_valid; w_dst <= m_dst
//       w_data  <= m_sel==01 ? m_ext : m_sel==11 ? mem_rd_data : m_alu
//   - flush: m_valid, w_valid <= 0. Flush beats stall. Data fields may keep stale values.
//   - stall (no flush): all M/W registers hold.
//   - Write port, combinational from W: wb_we = w_valid & (w_dst!=0); wb_addr=w_dst; wb_data=w_data.
//       Repeated identical writes while stalled are permitted (idempotent).
//   - Forwarding, combinational, 0-cycle, per operand i, priority top-down:
//       1. addr==0                      -> data 0, no hazard
//       2. m_valid & m_dst==addr:
//            m_sel==11                  -> hazard_i=1, data=op_rf_data_i
//            else                       -> data = m_sel==01 ? m_ext : m_alu
//       3. w_valid & w_dst==addr        -> w_data
//       4. otherwise                    -> op_rf_data_i
//   - Younger M always wins over W on the same address; W wins over the register file.
//   - load_use = |hazard. The block never stalls itself; an external unit drives stall/bubble.
//   - Reset mid-operation: contents discarded; wb_we drops immediately (async).
// STRUCTURE
//   - Package wb_pkg: WB_ALU=2'b00, WB_EXT=2'b01, WB_ALU2=2'b10, WB_MEM=2'b11;
//       default widths DATA_W/RADDR_W.
//   - Sub-module fwd_sel: one operand's compare/priority mux plus hazard bit,
//       instantiated NUM_OPS times via generate.
//   - Top level owns M/W registers and the write port.
// TESTING
//   1. Reset: rst_n=0 mid-stream -> wb_we=0, wb_addr=0, wb_data=0 asynchronously;
//      op_data = op_rf_data.
//   2. ALU fwd: ex add to r8 (reg_dst=1, sel=00, alu=0x1234); next cycle op_addr0=8
//      -> op_data0=0x1234 from M; cycle after -> 0x1234 from W, wb_we=1, wb_addr=8.
//   3. Priority: M dst=r5 alu=0xAA and W dst=r5 data=0xBB, op_addr1=5 -> op_data1=0xAA.
//      r0 with M dst=0 -> op_data=0, wb_we=0.
//   4. Load-use: M sel=11 dst=r9, op_addr0=9 -> load_use=1. Next cycle (W, mem_rd_data=0xCAFE)
//      -> load_use=0, op_data0=0xCAFE.
//   5. Stall/flush: stall=1 for 3 cycles -> M/W unchanged, wb_* stable.
//      stall=1 & flush=1 -> m_valid=w_valid=0, wb_we=0 next cycle.
//   6. Sel/RegDst: sel=01 ext=0xFFFF8000, reg_dst=0 rt=3 -> wb_addr=3, wb_data=0xFFFF8000;
//      sel=10 -> ALU value.

Source files
------------

// File: rtl/wb_pkg.sv
// Write-back select encodings and default widths shared by the
// write-back/bypass pipe and its forwarding sub-module.
package wb_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_EXT  = 2'b01;
  localparam logic [1:0] WB_ALU2 = 2'b10;
  localparam logic [1:0] WB_MEM  = 2'b11;

  localparam int WB_DATA_W  = 32;
  localparam int WB_RADDR_W = 5;

endpackage

// File: rtl/wb_bypass_pipe_fwd_sel.sv
// One read operand's bypass mux: M over W over register file,
// with a hazard flag when the matching M entry is a load.
module fwd_sel
  import wb_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RADDR_W = WB_RADDR_W
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic               m_valid,
  input  logic [RADDR_W-1:0] m_dst,
  input  logic [1:0]         m_sel,
  input  logic [DATA_W-1:0]  m_alu,
  input  logic [DATA_W-1:0]  m_ext,
  input  logic               w_valid,
  input  logic [RADDR_W-1:0] w_dst,
  input  logic [DATA_W-1:0]  w_data,
  output logic [DATA_W-1:0]  data,
  output logic               hazard
);

  logic w_m_hit;
  logic w_w_hit;

  assign w_m_hit = m_valid && (m_dst == addr);
  assign w_w_hit = w_valid && (w_dst == addr);

  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (addr == '0) begin
      data = '0;
    end else if (w_m_hit) begin
      // Load data is not available until W; decode must stall.
      if (m_sel == WB_MEM) begin
        hazard = 1'b1;
      end else if (m_sel == WB_EXT) begin
        data = m_ext;
      end else begin
        data = m_alu;
      end
    end else if (w_w_hit) begin
      data = w_data;
    end
  end

endmodule

// File: rtl/wb_bypass_pipe.sv
// EX/MEM and MEM/WB destination/write-back registers, register-file
// write port and per-operand forwarding with load-use detection.
module wb_bypass_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RADDR_W = WB_RADDR_W,
  parameter int NUM_OPS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        ex_valid,
  input  logic                        ex_wr_en,
  input  logic [RADDR_W-1:0]          ex_rt,
  input  logic [RADDR_W-1:0]          ex_rd,
  input  logic                        ex_reg_dst,
  input  logic [1:0]                  ex_wb_sel,
  input  logic [DATA_W-1:0]           ex_alu_res,
  input  logic [DATA_W-1:0]           ex_ext_res,
  input  logic [DATA_W-1:0]           mem_rd_data,
  input  logic [NUM_OPS*RADDR_W-1:0]  op_addr,
  input  logic [NUM_OPS*DATA_W-1:0]   op_rf_data,
  output logic [NUM_OPS*DATA_W-1:0]   op_data,
  output logic                        load_use,
  output logic                        wb_we,
  output logic [RADDR_W-1:0]          wb_addr,
  output logic [DATA_W-1:0]           wb_data
);

  logic               r_m_valid;
  logic [RADDR_W-1:0] r_m_dst;
  logic [1:0]         r_m_sel;
  logic [DATA_W-1:0]  r_m_alu;
  logic [DATA_W-1:0]  r_m_ext;
  logic               r_w_valid;
  logic [RADDR_W-1:0] r_w_dst;
  logic [DATA_W-1:0]  r_w_data;

  logic [DATA_W-1:0]  w_m_res;
  logic [NUM_OPS-1:0] w_hazard;

  always_comb begin
    case (r_m_sel)
      WB_EXT:  w_m_res = r_m_ext;
      WB_MEM:  w_m_res = mem_rd_data;
      default: w_m_res = r_m_alu;
    endcase
  end

  // Flush clears only the valid bits; payload may stay stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_dst   <= '0;
      r_m_sel   <= WB_ALU;
      r_m_alu   <= '0;
      r_m_ext   <= '0;
      r_w_valid <= 1'b0;
      r_w_dst   <= '0;
      r_w_data  <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_w_valid <= 1'b0;
    end else if (!stall) begin
      r_m_valid <= ex_valid & ex_wr_en;
      r_m_dst   <= ex_reg_dst ? ex_rd : ex_rt;
      r_m_sel   <= ex_wb_sel;
      r_m_alu   <= ex_alu_res;
      r_m_ext   <= ex_ext_res;
      r_w_valid <= r_m_valid;
      r_w_dst   <= r_m_dst;
      r_w_data  <= w_m_res;
    end
  end

  assign wb_we   = r_w_valid & (r_w_dst != '0);
  assign wb_addr = r_w_dst;
  assign wb_data = r_w_data;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    fwd_sel #(
      .DATA_W  (DATA_W),
      .RADDR_W (RADDR_W)
    ) u_fwd (
      .addr    (op_addr[i*RADDR_W +: RADDR_W]),
      .rf_data (op_rf_data[i*DATA_W +: DATA_W]),
      .m_valid (r_m_valid),
      .m_dst   (r_m_dst),
      .m_sel   (r_m_sel),
      .m_alu   (r_m_alu),
      .m_ext   (r_m_ext),
      .w_valid (r_w_valid),
      .w_dst   (r_w_dst),
      .w_data  (r_w_data),
      .data    (op_data[i*DATA_W +: DATA_W]),
      .hazard  (w_hazard[i])
    );
  end

  assign load_use = |w_hazard;

endmodule

// File: tb/tb_wb_bypass_pipe.sv
// Directed bench for wb_bypass_pipe: forwarding, priority, load-use,
// stall/flush, select decoding and asynchronous reset.
module tb_wb_bypass_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic        ex_wr_en;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        ex_reg_dst;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_ext_res;
  logic [31:0] mem_rd_data;
  logic [9:0]  op_addr;
  logic [63:0] op_rf_data;
  logic [63:0] op_data;
  logic        load_use;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_bypass_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_wr_en    (ex_wr_en),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_reg_dst  (ex_reg_dst),
    .ex_wb_sel   (ex_wb_sel),
    .ex_alu_res  (ex_alu_res),
    .ex_ext_res  (ex_ext_res),
    .mem_rd_data (mem_rd_data),
    .op_addr     (op_addr),
    .op_rf_data  (op_rf_data),
    .op_data     (op_data),
    .load_use    (load_use),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rdst,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] ext);
    ex_valid   = v;
    ex_wr_en   = 1'b1;
    ex_rt      = rt;
    ex_rd      = rd;
    ex_reg_dst = rdst;
    ex_wb_sel  = sel;
    ex_alu_res = alu;
    ex_ext_res = ext;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 5'd1, 5'd1, 1'b1, 2'b00, 32'h0BAD, 32'h0BAD);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    mem_rd_data = 32'h0;
    op_rf_data  = {32'h2222_2222, 32'h1111_1111};
    op_addr     = {5'd2, 5'd1};
    ex_idle();
    #12;
    chk("rst_we", 32'(wb_we), 32'h0);
    chk("rst_addr", 32'(wb_addr), 32'h0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_op0", op_data[31:0], 32'h1111_1111);
    chk("rst_op1", op_data[63:32], 32'h2222_2222);
    rst_n = 1'b1;
    tick();

    ex_set(1'b1, 5'd3, 5'd8, 1'b1, 2'b00, 32'h1234, 32'h0);
    tick();
    ex_idle();
    op_addr = {5'd2, 5'd8};
    #1;
    chk("alu_m_op0", op_data[31:0], 32'h1234);
    chk("alu_m_we", 32'(wb_we), 32'h0);
    tick();
    chk("alu_w_op0", op_data[31:0], 32'h1234);
    chk("alu_w_we", 32'(wb_we), 32'h1);
    chk("alu_w_addr", 32'(wb_addr), 32'd8);
    chk("alu_w_data", wb_data, 32'h1234);
    tick();
    chk("idle_we", 32'(wb_we), 32'h0);

    ex_set(1'b1, 5'd0, 5'd5, 1'b1, 2'b00, 32'hBB, 32'h0);
    tick();
    ex_set(1'b1, 5'd0, 5'd5, 1'b1, 2'b00, 32'hAA, 32'h0);
    tick();
    op_addr = {5'd5, 5'd8};
    #1;
    chk("prio_op1", op_data[63:32], 32'hAA);
    chk("prio_op0_rf", op_data[31:0], 32'h1111_1111);
    chk("prio_wdata", wb_data, 32'hBB);
    ex_set(1'b1, 5'd0, 5'd0, 1'b1, 2'b00, 32'h77, 32'h0);
    tick();
    op_addr = {5'd5, 5'd0};
    #1;
    chk("r0_m_op0", op_data[31:0], 32'h0);
    chk("r0_w5_op1", op_data[63:32], 32'hAA);
    ex_idle();
    tick();
    chk("r0_we", 32'(wb_we), 32'h0);
    chk("r0_w_op0", op_data[31:0], 32'h0);

    ex_set(1'b1, 5'd0, 5'd9, 1'b1, 2'b11, 32'h999, 32'h888);
    tick();
    ex_idle();
    op_addr     = {5'd2, 5'd9};
    mem_rd_data = 32'hCAFE;
    #1;
    chk("lu_flag", 32'(load_use), 32'h1);
    chk("lu_op0_rf", op_data[31:0], 32'h1111_1111);
    tick();
    mem_rd_data = 32'h0;
    #1;
    chk("lu_clear", 32'(load_use), 32'h0);
    chk("lu_w_op0", op_data[31:0], 32'hCAFE);
    chk("lu_w_addr", 32'(wb_addr), 32'd9);

    ex_set(1'b1, 5'd0, 5'd10, 1'b1, 2'b00, 32'h5555, 32'h0);
    tick();
    ex_set(1'b1, 5'd0, 5'd11, 1'b1, 2'b00, 32'h6666, 32'h0);
    tick();
    ex_set(1'b1, 5'd0, 5'd12, 1'b1, 2'b00, 32'h7777, 32'h0);
    stall   = 1'b1;
    op_addr = {5'd10, 5'd11};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_we", 32'(wb_we), 32'h1);
      chk("stl_addr", 32'(wb_addr), 32'd10);
      chk("stl_data", wb_data, 32'h5555);
      chk("stl_m_op0", op_data[31:0], 32'h6666);
    end
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    ex_idle();
    #1;
    chk("fl_we", 32'(wb_we), 32'h0);
    chk("fl_op0", op_data[31:0], 32'h1111_1111);
    chk("fl_op1", op_data[63:32], 32'h2222_2222);

    ex_set(1'b1, 5'd3, 5'd7, 1'b0, 2'b01, 32'h4321, 32'hFFFF_8000);
    tick();
    ex_set(1'b1, 5'd6, 5'd4, 1'b1, 2'b10, 32'h4321, 32'h0);
    op_addr = {5'd7, 5'd3};
    #1;
    chk("ext_m_op0", op_data[31:0], 32'hFFFF_8000);
    chk("rt_op1_rf", op_data[63:32], 32'h2222_2222);
    tick();
    ex_idle();
    #1;
    chk("ext_addr", 32'(wb_addr), 32'd3);
    chk("ext_data", wb_data, 32'hFFFF_8000);
    tick();
    chk("alu2_addr", 32'(wb_addr), 32'd4);
    chk("alu2_data", wb_data, 32'h4321);
    chk("alu2_we", 32'(wb_we), 32'h1);

    op_addr = {5'd2, 5'd4};
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(wb_we), 32'h0);
    chk("arst_addr", 32'(wb_addr), 32'h0);
    chk("arst_data", wb_data, 32'h0);
    chk("arst_op0", op_data[31:0], 32'h1111_1111);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
